// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// A granted requester keeps the transmitter until it sends a byte flagged last.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 200000,
    parameter int TO_W          = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_en,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   timeout_err,
    output logic                   arb_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ARB, LOAD, START, WAIT_DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [PTR_W-1:0]   pick;
    logic               pick_vld;
    logic               lock, lock_nxt;
    logic               last_q;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [TO_W-1:0]    to_cnt;
    logic               busy_p0, busy_p1, busy_s;
    logic [7:0]         req_bytes [NUM_REQ];
    int                 scan_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : PTR_W'(int'(p) + 1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!pick_vld && req_valid[PTR_W'(scan_idx)]) begin
                pick     = PTR_W'(scan_idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign busy_s   = busy_p1;
    assign tx_en    = rst_n;
    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            lock    <= 1'b0;
            grant   <= '0;
            tx_data <= 8'h00;
            last_q  <= 1'b0;
            to_cnt  <= '0;
            busy_p0 <= 1'b0;
            busy_p1 <= 1'b0;
        end else begin
            // tx_busy comes from the baud-clock domain
            busy_p0 <= tx_busy;
            busy_p1 <= busy_p0;
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            owner   <= owner_nxt;
            lock    <= lock_nxt;
            grant   <= grant_nxt;
            if (state == LOAD) begin
                tx_data <= req_bytes[owner];
                last_q  <= req_last[owner];
                to_cnt  <= '0;
            end else if (state == START) begin
                to_cnt  <= to_cnt + TO_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        owner_nxt   = owner;
        lock_nxt    = lock;
        grant_nxt   = grant;
        req_ready   = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (lock) begin
                    if (req_valid[owner]) state_nxt = LOAD;
                end else if (|req_valid) begin
                    state_nxt = ARB;
                end
            end
            ARB: begin
                if (pick_vld) begin
                    owner_nxt = pick;
                    grant_nxt = NUM_REQ'(1) << pick;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                req_ready = grant;
                state_nxt = START;
            end
            START: begin
                tx_start = 1'b1;
                if (busy_s) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == TO_W'(START_TIMEOUT - 1)) begin
                    // Unacknowledged start: drop the byte and release the owner
                    timeout_err = 1'b1;
                    lock_nxt    = 1'b0;
                    grant_nxt   = '0;
                    rr_ptr_nxt  = ptr_inc(owner);
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!busy_s) begin
                    if (last_q) begin
                        lock_nxt   = 1'b0;
                        grant_nxt  = '0;
                        rr_ptr_nxt = ptr_inc(owner);
                    end else begin
                        lock_nxt   = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
